// File: rtl/rd_alu_exec.sv
// Execute-stage ALU: single-cycle logic/add/sub, 1-bit-per-cycle serial shifter,
// valid/ready handshake on the operation and result sides.
module rd_alu_exec #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               op_valid_i,
   output logic               op_ready_o,
   input  logic [3:0]         ALUControl_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               res_valid_o,
   input  logic               res_ready_i,
   output logic [WIDTH-1:0]   result_o,
   output logic               zero_o,
   output logic               illegal_o
);

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4;
   localparam logic [3:0] ALU_SLL = 4'd5;
   localparam logic [3:0] ALU_SRL = 4'd6;
   localparam logic [3:0] ALU_SRA = 4'd7;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t               state_reg, state_next;
   logic [3:0]           op_reg;
   logic [WIDTH-1:0]     shift_reg;
   logic [SHAMT_W-1:0]   cnt_reg;
   logic [WIDTH-1:0]     result_reg;
   logic                 zero_reg;
   logic                 illegal_reg;

   logic                 accept;
   logic                 is_shift;
   logic                 is_legal;
   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     imm_res;
   logic [WIDTH-1:0]     shift_step;
   logic                 last_shift;

   assign accept     = op_valid_i & op_ready_o;
   assign shamt      = b_i[SHAMT_W-1:0];
   assign is_shift   = (ALUControl_i == ALU_SLL) || (ALUControl_i == ALU_SRL) ||
                       (ALUControl_i == ALU_SRA);
   assign is_legal   = (ALUControl_i <= ALU_SRA);
   assign last_shift = (cnt_reg == SHAMT_W'(1));

   // Single-cycle result; a zero-length shift simply passes operand A through.
   always_comb begin
      imm_res = '0;
      case (ALUControl_i)
         ALU_ADD: imm_res = a_i + b_i;
         ALU_SUB: imm_res = a_i - b_i;
         ALU_AND: imm_res = a_i & b_i;
         ALU_OR:  imm_res = a_i | b_i;
         ALU_XOR: imm_res = a_i ^ b_i;
         ALU_SLL, ALU_SRL, ALU_SRA: imm_res = a_i;
         default: imm_res = '0;
      endcase
   end

   always_comb begin
      shift_step = shift_reg;
      case (op_reg)
         ALU_SLL: shift_step = {shift_reg[WIDTH-2:0], 1'b0};
         ALU_SRL: shift_step = {1'b0, shift_reg[WIDTH-1:1]};
         ALU_SRA: shift_step = {shift_reg[WIDTH-1], shift_reg[WIDTH-1:1]};
         default: shift_step = shift_reg;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (is_shift && (shamt != '0)) ? SHIFT : DONE;
            end
         end
         SHIFT: begin
            if (last_shift) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (res_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      op_ready_o  = rst_ni && (state_reg == IDLE);
      res_valid_o = (state_reg == DONE);
   end

   // The shifter works on its own register so result_o keeps its previous value until the end.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         op_reg      <= '0;
         shift_reg   <= '0;
         cnt_reg     <= '0;
         result_reg  <= '0;
         zero_reg    <= 1'b0;
         illegal_reg <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  op_reg <= ALUControl_i;
                  if (is_shift && (shamt != '0)) begin
                     shift_reg <= a_i;
                     cnt_reg   <= shamt;
                  end else begin
                     result_reg  <= imm_res;
                     zero_reg    <= (imm_res == '0);
                     illegal_reg <= !is_legal;
                  end
               end
            end
            SHIFT: begin
               shift_reg <= shift_step;
               cnt_reg   <= cnt_reg - SHAMT_W'(1);
               if (last_shift) begin
                  result_reg  <= shift_step;
                  zero_reg    <= (shift_step == '0);
                  illegal_reg <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign result_o  = result_reg;
   assign zero_o    = zero_reg;
   assign illegal_o = illegal_reg;

endmodule
